// File: rtl/cave_input_decoder_if.sv
// cave_input_decoder_if: key/joystick inputs and packed player/service outputs of the input decoder.
interface cave_input_decoder_if;
  logic [10:0] ps2_key;
  logic [10:0] joystick_0;
  logic [10:0] joystick_1;
  logic [9:0]  player_1;
  logic [9:0]  player_2;
  logic [1:0]  service;
  modport master(output ps2_key, joystick_0, joystick_1, input player_1, player_2, service);
  modport slave(input ps2_key, joystick_0, joystick_1, output player_1, player_2, service);
endinterface

// File: rtl/cave_input_decoder.sv
// cave_input_decoder: ps2 key latches ORed with joysticks, coin pulse shaping, registered player buses.
// Optional CAVE_INPUT_PAUSE_TOGGLE_EN: pause bits toggle on each raw pause press instead of following the level.
module cave_input_decoder #(
  parameter int COIN_PULSE_CYCLES = 96000,
  parameter int COIN_GAP_CYCLES   = 96000
) (
  input logic clock,
  input logic reset_n,
  cave_input_decoder_if.slave io
);
  localparam int CMAX = COIN_PULSE_CYCLES > COIN_GAP_CYCLES ? COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT_REL} coin_t;
  logic armed, toggle_prev, ev, ext, pr;
  logic [7:0] code;
  logic [9:0] key_1, hit_1, raw_1, raw_2;
  logic [8:0] key_2, hit_2;
  logic [1:0] key_s, hit_s, svc, rc, rp, coin_prev, rise, coin, pause;
  logic [7:0] btn_1, btn_2;
  coin_t st [2];
  coin_t st_nx [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_nx [2];
  function automatic logic [9:0] jmap(input logic [9:0] j);
    return {j[9:4], j[0], j[1], j[2], j[3]};
  endfunction
  assign code = io.ps2_key[7:0];
  assign ext = io.ps2_key[8];
  assign pr = io.ps2_key[9];
  assign ev = armed && (io.ps2_key[10] != toggle_prev);
  // hit vectors are in output bit order: {pause,coin,start,b3,b2,b1,right,left,down,up}
  assign hit_1 = {10{ev}} & {!ext && code == 8'h4D, !ext && code == 8'h2E, !ext && code == 8'h16,
                             !ext && code == 8'h29, code == 8'h11, code == 8'h14, ext && code == 8'h74,
                             ext && code == 8'h6B, ext && code == 8'h72, ext && code == 8'h75};
  assign hit_2 = {9{ev && !ext}} & {code == 8'h36, code == 8'h1E, code == 8'h15, code == 8'h1B,
                                   code == 8'h1C, code == 8'h34, code == 8'h23, code == 8'h2B, code == 8'h2D};
  assign hit_s = {2{ev && !ext}} & {code == 8'h45, code == 8'h46};
  assign raw_1 = key_1 | jmap(io.joystick_0[9:0]);
  assign raw_2 = {1'b0, key_2} | jmap(io.joystick_1[9:0]);
  assign rc = {raw_2[8], raw_1[8]};
  assign rp = {raw_2[9], raw_1[9]};
  assign rise = {2{armed}} & rc & ~coin_prev;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      armed <= 1'b0;
      toggle_prev <= 1'b0;
      key_1 <= '0;
      key_2 <= '0;
      key_s <= '0;
      btn_1 <= '0;
      btn_2 <= '0;
      svc <= '0;
      coin_prev <= '0;
    end else begin
      armed <= 1'b1;
      toggle_prev <= io.ps2_key[10];
      key_1 <= (key_1 & ~hit_1) | (hit_1 & {10{pr}});
      key_2 <= (key_2 & ~hit_2) | (hit_2 & {9{pr}});
      key_s <= (key_s & ~hit_s) | (hit_s & {2{pr}});
      btn_1 <= raw_1[7:0];
      btn_2 <= raw_2[7:0];
      svc <= key_s;
      coin_prev <= armed ? rc : 2'b00;
    end
`ifdef CAVE_INPUT_PAUSE_TOGGLE_EN
  logic [1:0] pause_prev;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pause <= '0;
      pause_prev <= '0;
    end else begin
      pause <= pause ^ (rp & ~pause_prev);
      pause_prev <= rp;
    end
`else
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) pause <= '0;
    else pause <= rp;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st <= '{default: IDLE};
      cnt <= '{default: '0};
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
    end
  // edges during PULSE/GAP are ignored; a coin still held at the end of GAP must be released first
  always_comb
    for (int i = 0; i < 2; i++) begin
      st_nx[i] = st[i];
      cnt_nx[i] = cnt[i];
      case (st[i])
        IDLE: if (rise[i]) begin
          st_nx[i] = PULSE;
          cnt_nx[i] = CW'(COIN_PULSE_CYCLES - 1);
        end
        PULSE: if (cnt[i] == '0) begin
          st_nx[i] = GAP;
          cnt_nx[i] = CW'(COIN_GAP_CYCLES - 1);
        end else cnt_nx[i] = cnt[i] - CW'(1);
        GAP: if (cnt[i] == '0) st_nx[i] = rc[i] ? WAIT_REL : IDLE;
             else cnt_nx[i] = cnt[i] - CW'(1);
        default: if (!rc[i]) st_nx[i] = IDLE;
      endcase
    end
  always_comb
    for (int i = 0; i < 2; i++) coin[i] = st[i] == PULSE;
  assign io.player_1 = {pause[0], coin[0], btn_1};
  assign io.player_2 = {pause[1], coin[1], btn_2};
  assign io.service = svc;
endmodule

// File: tb/tb_cave_input_decoder.sv
// tb_cave_input_decoder: scoreboard bench; each tick queues the outputs expected after that clock edge.
module tb_cave_input_decoder;
  logic clock = 1'b0;
  logic reset_n;
  int n_chk = 0;
  int n_err = 0;
  logic [9:0] e1, e2;
  logic [1:0] es;
  typedef struct {
    string tag;
    logic [9:0] p1;
    logic [9:0] p2;
    logic [1:0] svc;
  } exp_t;
  exp_t q[$];
  cave_input_decoder_if io();
  cave_input_decoder #(.COIN_PULSE_CYCLES(4), .COIN_GAP_CYCLES(3)) dut (
    .clock(clock), .reset_n(reset_n), .io(io)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input string tag);
    @(posedge clock);
    #1;
    q.push_back('{tag, e1, e2, es});
  endtask
  task automatic send(input logic [7:0] c, input logic x, input logic p);
    io.ps2_key = {~io.ps2_key[10], p, x, c};
  endtask
  always @(negedge clock)
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check({x.tag, "_p1"}, io.player_1, x.p1);
      check({x.tag, "_p2"}, io.player_2, x.p2);
      check({x.tag, "_svc"}, {8'd0, io.service}, {8'd0, x.svc});
    end
  initial begin
    reset_n = 1'b0;
    io.ps2_key = 11'h400;
    io.joystick_0 = '0;
    io.joystick_1 = '0;
    e1 = '0; e2 = '0; es = '0;
    #3;
    check("rst_p1", io.player_1, 10'd0);
    check("rst_p2", io.player_2, 10'd0);
    check("rst_svc", {8'd0, io.service}, 10'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (20) tick("idle");
    send(8'h75, 1'b0, 1'b1); tick("up_ext0"); tick("up_ext0");
    send(8'h75, 1'b1, 1'b1); tick("up_n1"); e1[0] = 1'b1; tick("up_n2");
    send(8'h72, 1'b1, 1'b1); tick("down_n1"); e1[1] = 1'b1; tick("updown");
    send(8'h75, 1'b0, 1'b0); tick("uprel_ext0"); tick("uprel_ext0");
    send(8'h75, 1'b1, 1'b0); tick("uprel_n1"); e1[0] = 1'b0; tick("uprel_n2");
    send(8'h72, 1'b1, 1'b0); tick("downrel"); e1[1] = 1'b0; tick("downrel");
    io.joystick_0 = 11'h401; e1[3] = 1'b1; tick("joy_right");
    io.joystick_0 = 11'h008; e1[3] = 1'b0; e1[0] = 1'b1; tick("joy_up");
    io.joystick_0 = 11'h000; e1[0] = 1'b0; tick("joy_none");
    send(8'h11, 1'b1, 1'b1); tick("b2_ext"); e1[5] = 1'b1; tick("b2_ext");
    send(8'h11, 1'b0, 1'b0); tick("b2_rel"); e1[5] = 1'b0; tick("b2_rel");
    send(8'h1C, 1'b0, 1'b1); tick("p2b1_key"); e2[4] = 1'b1; tick("p2b1_key");
    io.joystick_1 = 11'h010; tick("p2b1_both");
    send(8'h1C, 1'b0, 1'b0); tick("p2b1_keyrel"); tick("p2b1_joyheld");
    io.joystick_1 = 11'h000; e2[4] = 1'b0; tick("p2b1_joyrel");
    send(8'h45, 1'b0, 1'b1); tick("svc2"); es = 2'b10; tick("svc2");
    send(8'h46, 1'b0, 1'b1); tick("svc1"); es = 2'b11; tick("svc1");
    send(8'h45, 1'b0, 1'b0); tick("svc2rel"); es = 2'b01; tick("svc2rel");
    send(8'h46, 1'b1, 1'b0); tick("svc1_extrel"); tick("svc1_extrel");
    send(8'h46, 1'b0, 1'b0); tick("svc1rel"); es = 2'b00; tick("svc1rel");
    send(8'h2D, 1'b0, 1'b1); io.joystick_1 = 11'h008; e2[0] = 1'b1; tick("sim_up"); tick("sim_up");
    io.joystick_1 = 11'h000; tick("sim_keyonly");
    send(8'h2D, 1'b0, 1'b0); tick("sim_rel"); e2[0] = 1'b0; tick("sim_rel");
    io.joystick_0 = 11'h100; e1[8] = 1'b1;
    repeat (4) tick("coin_pulse");
    e1[8] = 1'b0;
    repeat (16) tick("coin_held");
    io.joystick_0 = 11'h000; tick("coin_rel");
    io.joystick_0 = 11'h100; e1[8] = 1'b1;
    repeat (4) tick("coin2_pulse");
    e1[8] = 1'b0;
    repeat (4) tick("coin2_gap");
    io.joystick_0 = 11'h000;
    repeat (4) tick("coin2_idle");
    send(8'h2E, 1'b0, 1'b1); tick("kcoin_latch");
    send(8'h2E, 1'b0, 1'b0); e1[8] = 1'b1; tick("kcoin_pulse");
    tick("kcoin_pulse");
    send(8'h2E, 1'b0, 1'b1); tick("kcoin_repress");
    send(8'h2E, 1'b0, 1'b0); tick("kcoin_pulse");
    e1[8] = 1'b0;
    repeat (6) tick("kcoin_norepeat");
    send(8'h2E, 1'b0, 1'b1); tick("kcoin2_latch");
    e1[8] = 1'b1;
    repeat (4) tick("kcoin2_pulse");
    send(8'h2E, 1'b0, 1'b0); e1[8] = 1'b0;
    repeat (8) tick("kcoin2_tail");
    send(8'h4D, 1'b0, 1'b1); tick("pause1"); e1[9] = 1'b1; tick("pause1");
    send(8'h4D, 1'b0, 1'b0); tick("pause1rel");
`ifndef CAVE_INPUT_PAUSE_TOGGLE_EN
    e1[9] = 1'b0;
`endif
    tick("pause1rel");
    send(8'h4D, 1'b0, 1'b1); tick("pause2");
`ifdef CAVE_INPUT_PAUSE_TOGGLE_EN
    e1[9] = 1'b0;
`else
    e1[9] = 1'b1;
`endif
    tick("pause2");
    send(8'h4D, 1'b0, 1'b0); tick("pause2rel"); e1[9] = 1'b0; tick("pause2rel");
    io.joystick_1 = 11'h100; e2[8] = 1'b1; tick("p2coin"); tick("p2coin");
    @(negedge clock); #1 reset_n = 1'b0;
    #1 check("async_rst_p2", io.player_2, 10'd0);
    check("async_rst_p1", io.player_1, 10'd0);
    e1 = '0; e2 = '0; es = '0;
    @(posedge clock); #1 reset_n = 1'b1;
    tick("rearm");
    e2[8] = 1'b1;
    repeat (4) tick("held_thru_rst");
    e2[8] = 1'b0;
    repeat (6) tick("held_norepeat");
    io.joystick_1 = 11'h000;
    repeat (3) @(negedge clock);
    #1 check("drain", 10'(q.size()), 10'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
